micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Sequences the CPU datapath by issuing 28-bit microinstructions from an on-chip
//  control store instead of hand-selected words. Sits between the top-level board
//  wrapper and the cpu core; its mir_out port drives the core's mir input.
//  Runs a microprogram from start_addr until a halt word, inserting idle cycles
//  after memory operations.
// PARAMETERS
//  MIR_W     28  microinstruction width
//  AW        4   control-store address width (DEPTH = 2**AW words)
//  MEM_WAIT  2   NOP cycles inserted after any word with MEM bits [19:18] != 0
// PORTS
//  clock       in   1      system clock, rising edge
//  reset_n     in   1      asynchronous active-low reset
//  start       in   1      begin program at start_addr (sampled in IDLE only)
//  start_addr  in   AW     first control-store address
//  abort       in   1      synchronous stop; priority over everything but reset
//  cs_we       in   1      control-store write strobe (honoured only when busy=0)
//  cs_addr     in   AW     control-store write address
//  cs_wdata    in   MIR_W  control-store write data
//  mir_out     out  MIR_W  microinstruction to cpu core; 0 = NOP
//  upc         out  AW     address of the word being fetched/issued
//  busy        out  1      high in FETCH/ISSUE/WAIT
//  done        out  1      one-cycle pulse on normal or overrun completion
//  overrun     out  1      sticky: program ran past DEPTH-1; cleared by next start
// BEHAVIOUR
//  Reset: state=IDLE, mir_out=0, upc=0, busy=0, done=0, overrun=0; store contents undefined.
//  All outputs registered. Word == all-zeros is HALT.
//  IDLE  : start=1 -> FETCH, upc<=start_addr, overrun<=0.
//  FETCH : synchronous store read of upc; mir_out=0. -> ISSUE.
//  ISSUE : word==0 -> DONE (mir_out stays 0). Else mir_out=word for exactly 1 cycle;
//          then MEM bits set -> WAIT; upc==DEPTH-1 -> DONE with overrun<=1;
//          else upc<=upc+1 -> FETCH.
//  WAIT  : mir_out=0 for MEM_WAIT cycles (counter), then same exit rules as ISSUE
//          (overrun check, else upc+1 -> FETCH). MEM_WAIT=0 skips WAIT.
//  DONE  : done=1 for one cycle, busy=0 -> IDLE. start here is ignored.
//  Latency: start at cycle t -> first word on mir_out at t+2; non-memory words
//  issue every 2 cycles; memory words every 2+MEM_WAIT cycles.
//  abort in any busy state: next cycle IDLE, mir_out=0, no done pulse, overrun unchanged.
//  cs_we while busy=1: write dropped, store unchanged. start while busy: ignored.
//  Simultaneous cs_we and start in IDLE: write completes; FETCH reads new data if same address.
//  reset_n low mid-program: immediate return to reset values; store is not cleared.
// CONFIGURATION
//  MSEQ_STEP_EN defined: extra input step (1 bit). When step_mode-equivalent
//   behaviour is active, FETCH->ISSUE advances only on a cycle with step=1;
//   each step pulse issues exactly one word. step held high = free-run.
//  MSEQ_STEP_EN undefined: no step port; FETCH->ISSUE unconditional.
// STRUCTURE
//  Package mseq_pkg: state enum (IDLE, FETCH, ISSUE, WAIT, DONE), MIR_W,
//   field constants MEM_WR_BIT=19, MEM_RD_BIT=18, HALT_WORD='0.
//  Sub-module mseq_cstore: DEPTH x MIR_W single-port RAM, sync write,
//   sync read (1-cycle), write/read arbitration by busy.
//  Top: FSM, upc, wait counter, output registers.
// TESTING
//  1. Load 0:001000000000000000000001000 style ALU word, 1:0 (HALT); start_addr=0 ->
//     mir_out=word 0 at t+2 only, done pulse at t+4, busy low at t+5, overrun=0.
//  2. Word with bit19=1 at addr 2, MEM_WAIT=2 -> mir_out nonzero 1 cycle, then 0 for
//     1+2 cycles before addr 3 issues; spacing 4 cycles.
//  3. Fill all 16 words nonzero, start at 14 -> words 14,15 issued, done pulse,
//     overrun=1; next start clears overrun.
//  4. abort during WAIT -> IDLE next cycle, mir_out=0, no done; restart works.
//  5. cs_we to addr 5 while busy -> read back after run shows old value;
//     reset_n low mid-run -> all outputs 0 same cycle, store retained.
//  6. MSEQ_STEP_EN: step pulses every 10 cycles -> one word issued per pulse.

Source files
------------

// File: rtl/mseq_pkg.sv
// mseq_pkg: shared state encoding and microword field constants
// for the micro_sequencer control-store sequencer.
package mseq_pkg;

  localparam int MIR_W      = 28;
  localparam int MEM_WR_BIT = 19;
  localparam int MEM_RD_BIT = 18;

  localparam logic [MIR_W-1:0] HALT_WORD = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mseq_cstore.sv
// mseq_cstore: single-port control store, sync write and 1-cycle read.
// The sequencer owns the port while busy; writes are honoured only when idle.
module mseq_cstore #(
  parameter int MIR_W = 28,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             busy,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [MIR_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [MIR_W-1:0] rdata
);

  logic [MIR_W-1:0] mem [2**AW];
  logic [AW-1:0]    addr;

  assign addr = busy ? raddr : waddr;

  always_ff @(posedge clock) begin
    if (we && !busy)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: issues microwords from a control store until HALT.
// Optional single-step input is enabled by defining MSEQ_STEP_EN.
module micro_sequencer #(
  parameter int MIR_W    = 28,
  parameter int AW       = 4,
  parameter int MEM_WAIT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic             abort,
`ifdef MSEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             cs_we,
  input  logic [AW-1:0]    cs_addr,
  input  logic [MIR_W-1:0] cs_wdata,
  output logic [MIR_W-1:0] mir_out,
  output logic [AW-1:0]    upc,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  import mseq_pkg::*;

  localparam int WCW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

  state_t           state, nxt;
  logic [MIR_W-1:0] rdata, mir_n;
  logic [AW-1:0]    upc_n;
  logic [WCW-1:0]   wcnt, wcnt_n;
  logic             done_n, ovr_n;
  logic             go, last, mem_op, halt;

`ifdef MSEQ_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign last   = &upc;
  assign mem_op = rdata[MEM_WR_BIT] | rdata[MEM_RD_BIT];
  assign halt   = (rdata == MIR_W'(HALT_WORD));

  mseq_cstore #(
    .MIR_W(MIR_W),
    .AW   (AW)
  ) u_cstore (
    .clock(clock),
    .busy (busy),
    .we   (cs_we),
    .waddr(cs_addr),
    .wdata(cs_wdata),
    .raddr(upc),
    .rdata(rdata)
  );

  always_comb begin
    nxt    = state;
    upc_n  = upc;
    mir_n  = '0;
    wcnt_n = wcnt;
    done_n = 1'b0;
    ovr_n  = overrun;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            nxt   = FETCH;
            upc_n = start_addr;
            ovr_n = 1'b0;
          end
        end
        FETCH: begin
          if (go)
            nxt = ISSUE;
        end
        ISSUE: begin
          if (halt) begin
            nxt    = DONE;
            done_n = 1'b1;
          end else begin
            mir_n = rdata;
            if (mem_op && MEM_WAIT > 0) begin
              nxt    = WAIT;
              wcnt_n = WCW'(MEM_WAIT - 1);
            end else if (last) begin
              nxt    = DONE;
              done_n = 1'b1;
              ovr_n  = 1'b1;
            end else begin
              nxt   = FETCH;
              upc_n = upc + 1'b1;
            end
          end
        end
        WAIT: begin
          if (wcnt != '0) begin
            wcnt_n = wcnt - 1'b1;
          end else if (last) begin
            nxt    = DONE;
            done_n = 1'b1;
            ovr_n  = 1'b1;
          end else begin
            nxt   = FETCH;
            upc_n = upc + 1'b1;
          end
        end
        DONE: nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      upc     <= '0;
      mir_out <= '0;
      wcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= nxt;
      upc     <= upc_n;
      mir_out <= mir_n;
      wcnt    <= wcnt_n;
      busy    <= (nxt == FETCH) || (nxt == ISSUE) || (nxt == WAIT);
      done    <= done_n;
      overrun <= ovr_n;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized scoreboard bench for micro_sequencer.
// Expected issue/done events come from a program-walk reference model.
module tb_micro_sequencer;

  localparam int MW       = 28;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int MEM_WAIT = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          abort = 1'b0;
  logic          cs_we = 1'b0;
  logic [AW-1:0] cs_addr = '0;
  logic [MW-1:0] cs_wdata = '0;
  logic [MW-1:0] mir_out;
  logic [AW-1:0] upc;
  logic          busy, done, overrun;
`ifdef MSEQ_STEP_EN
  logic          step = 1'b1;
`endif

  micro_sequencer #(
    .MIR_W   (MW),
    .AW      (AW),
    .MEM_WAIT(MEM_WAIT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .abort     (abort),
`ifdef MSEQ_STEP_EN
    .step      (step),
`endif
    .cs_we     (cs_we),
    .cs_addr   (cs_addr),
    .cs_wdata  (cs_wdata),
    .mir_out   (mir_out),
    .upc       (upc),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {int c; logic [MW-1:0] w;} ev_t;
  typedef struct {int c; bit o;} dn_t;

  ev_t           exp_q[$];
  dn_t           done_q[$];
  ev_t           me;
  dn_t           md;
  logic [MW-1:0] mdl [DEPTH];
  bit            mdl_ovr;
  bit            chk_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  // Monitor: every nonzero microword and every done pulse must match the queue head.
  always @(negedge clock) begin
    if (reset_n && chk_en) begin
      if (mir_out != '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mir_unexpected cyc=%0d got=%h want=none", cyc, mir_out);
        end else begin
          me = exp_q.pop_front();
          if (me.c != cyc || me.w != mir_out) begin
            bad++;
            $display("FAIL mir_issue cyc=%0d got=%h want=%h@%0d",
                     cyc, mir_out, me.w, me.c);
          end
        end
      end
      if (done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d", cyc);
        end else begin
          md = done_q.pop_front();
          if (md.c != cyc || md.o != overrun) begin
            bad++;
            $display("FAIL done_pulse cyc=%0d ovr=%0b want=%0d ovr=%0b",
                     cyc, overrun, md.c, md.o);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  task automatic load(input int a, input logic [MW-1:0] d);
    mdl[a]   = d;
    cs_we    = 1'b1;
    cs_addr  = AW'(a);
    cs_wdata = d;
    tick();
    cs_we = 1'b0;
  endtask

  // Walk the program: a word issues 2 edges after its fetch begins,
  // memory words delay the next fetch by MEM_WAIT more edges.
  task automatic model(input int sa, input int t0, input int lim, output int endc);
    int a;
    int f;
    int n;
    logic [MW-1:0] w;
    a    = sa;
    f    = t0;
    endc = -1;
    for (int k = 0; k <= DEPTH && endc < 0; k++) begin
      w = mdl[a];
      if (w == '0) begin
        endc    = f + 2;
        mdl_ovr = 1'b0;
        if (endc < lim) done_q.push_back('{endc, 1'b0});
      end else begin
        if (f + 2 < lim) exp_q.push_back('{f + 2, w});
        n = f + 2 + ((w[19] | w[18]) ? MEM_WAIT : 0);
        if (a == DEPTH - 1) begin
          endc    = n;
          mdl_ovr = 1'b1;
          if (n < lim) done_q.push_back('{n, 1'b1});
        end else begin
          a++;
          f = n;
        end
      end
    end
    if (endc >= lim) begin
      endc    = lim;
      mdl_ovr = 1'b0;
    end
  endtask

  task automatic run(input int sa, input int abort_rel, input bit wr_now,
                     input logic [MW-1:0] wd, input bit wb);
    int t0;
    int lim;
    int endc;
    t0  = cyc + 1;
    lim = (abort_rel > 0) ? t0 + abort_rel : 32'h4000_0000;
    if (wr_now) begin
      mdl[sa]  = wd;
      cs_we    = 1'b1;
      cs_addr  = AW'(sa);
      cs_wdata = wd;
    end
    model(sa, t0, lim, endc);
    start      = 1'b1;
    start_addr = AW'(sa);
    tick();
    start = 1'b0;
    cs_we = 1'b0;
    chk("start_busy_ovr", {busy, overrun}, 2'b10);
    if (wb) begin
      cs_we    = 1'b1;
      cs_addr  = AW'(5);
      cs_wdata = MW'($urandom);
    end
    while (cyc < endc) begin
      if (cyc + 1 == lim) abort = 1'b1;
      tick();
      abort = 1'b0;
      cs_we = 1'b0;
    end
    if (endc == lim)
      chk("abort_idle", {busy, done, mir_out}, '0);
    tick();
    chk("end_busy", busy, 1'b0);
    chk("end_overrun", overrun, mdl_ovr);
    chk("end_queues", exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  function automatic logic [MW-1:0] rnd_word(input bit nz);
    logic [MW-1:0] w;
    int r;
    w = MW'($urandom);
    r = $urandom_range(0, 7);
    if (r < 4) w[19:18] = 2'b00;
    if (w == '0 || (!nz && r == 7)) w = nz ? MW'(1) : '0;
    return w;
  endfunction

  initial begin
    int n;
    tick();
    tick();
    chk("reset_state", {mir_out, upc, busy, done, overrun}, '0);
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // basic ALU word then HALT
    load(0, 28'h0200008);
    load(1, '0);
    run(0, 0, 1'b0, '0, 1'b0);

    // memory word spacing
    load(2, 28'h0080001);
    load(3, 28'h0000010);
    load(4, '0);
    run(2, 0, 1'b0, '0, 1'b0);

    // overrun past the last word, then cleared by the next start
    for (int i = 0; i < DEPTH; i++) load(i, rnd_word(1'b1));
    run(14, 0, 1'b0, '0, 1'b0);
    run(15, 0, 1'b0, '0, 1'b0);

    // abort while waiting after a memory word, then restart
    load(0, 28'h0000021);
    load(1, 28'h0000042);
    load(2, 28'h0040084);
    load(3, 28'h0000108);
    load(4, '0);
    run(0, 7, 1'b0, '0, 1'b0);
    run(0, 0, 1'b0, '0, 1'b0);

    // write coinciding with start at the start address
    run(3, 0, 1'b1, 28'h0000abc, 1'b0);

    // write while busy is dropped
    load(5, 28'h0123456);
    load(6, '0);
    run(0, 0, 1'b0, '0, 1'b1);
    run(5, 0, 1'b0, '0, 1'b0);

    // reset mid-run clears outputs, keeps the store
    chk_en     = 1'b0;
    start      = 1'b1;
    start_addr = '0;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("reset_midrun", {mir_out, upc, busy, done, overrun}, '0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;
    run(5, 0, 1'b0, '0, 1'b0);

    // randomized programs, starts, aborts and blocked writes
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DEPTH; i++) load(i, rnd_word(1'b0));
      run($urandom_range(0, DEPTH - 1),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0,
          $urandom_range(0, 3) == 0, rnd_word(1'b1),
          $urandom_range(0, 1) == 1);
    end

`ifdef MSEQ_STEP_EN
    for (int i = 0; i < 4; i++) load(i, 28'h0000100 + MW'(i));
    load(4, '0);
    chk_en     = 1'b0;
    step       = 1'b0;
    start      = 1'b1;
    start_addr = '0;
    tick();
    start = 1'b0;
    repeat (4) begin
      repeat (9) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      n = 0;
      repeat (9) begin
        if (mir_out != '0) n++;
        tick();
      end
      chk("step_one_word", n, 1);
    end
    step = 1'b1;
    repeat (6) tick();
    chk("step_end_busy", busy, 1'b0);
    chk_en = 1'b1;
`endif

    n = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
